booth_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one n-bit Booth multiplier between two requesters. It latches the winning requester's operands and drives the multiplier's Start/Mplier/Mcand pins, then follows the multiplier's Done pulse. It returns the captured product to the winner with a one-cycle acknowledge. The block sits between the client logic and the `booth` datapath and replaces manual switch/KEY sequencing.

---
 rtl/booth_arbiter.sv | 159 +++++++++++++++
 tb/tb_booth_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one Booth multiplier between two requesters:
// grants, drives Start/operands, follows Done, returns the product with a one-cycle ack.
module booth_arbiter #(
  parameter int N            = 8,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic           Clock,
  input  logic           Resetn,
  input  logic           iReq0,
  input  logic           iReq1,
  input  logic [N-1:0]   iMplier0,
  input  logic [N-1:0]   iMcand0,
  input  logic [N-1:0]   iMplier1,
  input  logic [N-1:0]   iMcand1,
  output logic           oAck0,
  output logic           oAck1,
  output logic [2*N-1:0] oProduct,
  output logic           oErr,
  output logic           oBusy,
  output logic           oStart,
  output logic [N-1:0]   oMplier,
  output logic [N-1:0]   oMcand,
  input  logic           iDone,
  input  logic [2*N-1:0] iProduct
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RESP    = 3'd4
  } state_t;

  localparam logic [3:0] START_LAST   = 4'(START_CYCLES - 1);
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t           state_reg;
  logic             last_reg;
  logic             id_reg;
  logic [3:0]       start_cnt_reg;
  logic [7:0]       wait_cnt_reg;
  logic             start_reg;
  logic             ack0_reg;
  logic             ack1_reg;
  logic             busy_reg;
  logic             err_reg;
  logic [2*N-1:0]   product_reg;
  logic [N-1:0]     mplier_reg;
  logic [N-1:0]     mcand_reg;
  logic             grant_id;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_id = 1'b0;
    if (iReq0 && iReq1)
      grant_id = ~last_reg;
    else if (iReq1)
      grant_id = 1'b1;
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_reg     <= IDLE;
      last_reg      <= 1'b1;
      id_reg        <= 1'b0;
      start_cnt_reg <= '0;
      wait_cnt_reg  <= '0;
      start_reg     <= 1'b0;
      ack0_reg      <= 1'b0;
      ack1_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      product_reg   <= '0;
      mplier_reg    <= '0;
      mcand_reg     <= '0;
    end else begin
      ack0_reg <= 1'b0;
      ack1_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (iReq0 || iReq1) begin
            state_reg     <= START;
            id_reg        <= grant_id;
            mplier_reg    <= grant_id ? iMplier1 : iMplier0;
            mcand_reg     <= grant_id ? iMcand1 : iMcand0;
            start_reg     <= 1'b1;
            busy_reg      <= 1'b1;
            start_cnt_reg <= START_LAST;
          end
        end
        START: begin
          // Done is deliberately ignored here; Start always runs its full length.
          if (start_cnt_reg == 4'd0) begin
            state_reg    <= WAIT_HI;
            start_reg    <= 1'b0;
            wait_cnt_reg <= '0;
          end else begin
            start_cnt_reg <= start_cnt_reg - 4'd1;
          end
        end
        WAIT_HI: begin
          if (iDone) begin
            state_reg    <= WAIT_LO;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            state_reg    <= RESP;
            err_reg      <= 1'b1;
            product_reg  <= '0;
            ack0_reg     <= ~id_reg;
            ack1_reg     <= id_reg;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        WAIT_LO: begin
          if (!iDone) begin
            state_reg    <= RESP;
            product_reg  <= iProduct;
            ack0_reg     <= ~id_reg;
            ack1_reg     <= id_reg;
            wait_cnt_reg <= '0;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            state_reg    <= RESP;
            err_reg      <= 1'b1;
            product_reg  <= '0;
            ack0_reg     <= ~id_reg;
            ack1_reg     <= id_reg;
            wait_cnt_reg <= '0;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 8'd1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          last_reg  <= id_reg;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          start_reg <= 1'b0;
        end
      endcase
    end
  end

  assign oAck0    = ack0_reg;
  assign oAck1    = ack1_reg;
  assign oProduct = product_reg;
  assign oErr     = err_reg;
  assign oBusy    = busy_reg;
  assign oStart   = start_reg;
  assign oMplier  = mplier_reg;
  assign oMcand   = mcand_reg;

endmodule

// File: tb/tb_booth_arbiter.sv
// Bench for booth_arbiter: stand-in multiplier, transaction-timestamp reference model,
// per-cycle output comparison plus directed scenarios and a randomized run.
module tb_booth_arbiter;
  localparam int N  = 8;
  localparam int S  = 2;
  localparam int TO = 255;

  logic        Clock = 1'b0;
  logic        Resetn = 1'b0;
  logic        iReq0 = 1'b0, iReq1 = 1'b0;
  logic [7:0]  iMplier0 = '0, iMcand0 = '0, iMplier1 = '0, iMcand1 = '0;
  logic        iDone = 1'b0;
  logic [15:0] iProduct = '0;
  logic        oAck0, oAck1, oErr, oBusy, oStart;
  logic [15:0] oProduct;
  logic [7:0]  oMplier, oMcand;

  always #5 Clock = ~Clock;

  booth_arbiter #(.N(N), .START_CYCLES(S), .TIMEOUT(TO)) dut (
    .Clock(Clock), .Resetn(Resetn),
    .iReq0(iReq0), .iReq1(iReq1),
    .iMplier0(iMplier0), .iMcand0(iMcand0),
    .iMplier1(iMplier1), .iMcand1(iMcand1),
    .oAck0(oAck0), .oAck1(oAck1), .oProduct(oProduct),
    .oErr(oErr), .oBusy(oBusy), .oStart(oStart),
    .oMplier(oMplier), .oMcand(oMcand),
    .iDone(iDone), .iProduct(iProduct)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction at a time, tracked by edge timestamps.
  int          ecount = 0;
  bit          m_busy = 0, m_last = 1, m_id = 0;
  int          g_edge = 0, h_edge = -1, ack_edge = -1;
  logic [7:0]  exp_mpl = '0, exp_mcd = '0;
  logic [15:0] exp_prod = '0;
  bit          exp_start = 0, exp_busy = 0, exp_ack0 = 0, exp_ack1 = 0, exp_err = 0;
  logic signed [15:0] pa, pb;

  task automatic model_finish(input bit timed_out);
    ack_edge = ecount;
    if (m_id) exp_ack1 = 1; else exp_ack0 = 1;
    if (timed_out) begin
      exp_prod = '0;
      exp_err  = 1;
    end else begin
      pa = $signed(exp_mpl);
      pb = $signed(exp_mcd);
      exp_prod = pa * pb;
    end
  endtask

  always begin
    @(posedge Clock or negedge Resetn);
    if (!Resetn) begin
      m_busy = 0; m_last = 1; ack_edge = -1; h_edge = -1;
      exp_mpl = '0; exp_mcd = '0; exp_prod = '0;
      exp_start = 0; exp_busy = 0; exp_ack0 = 0; exp_ack1 = 0; exp_err = 0;
    end else begin
      ecount++;
      exp_ack0 = 0;
      exp_ack1 = 0;
      if (!m_busy) begin
        if (iReq0 || iReq1) begin
          m_id = (iReq0 && iReq1) ? !m_last : !iReq0;
          exp_mpl = m_id ? iMplier1 : iMplier0;
          exp_mcd = m_id ? iMcand1 : iMcand0;
          m_busy = 1; g_edge = ecount; h_edge = -1; ack_edge = -1;
        end
      end else if (ack_edge >= 0) begin
        m_busy = 0;
        m_last = m_id;
      end else if (ecount > g_edge + S) begin
        if (h_edge < 0) begin
          if (iDone) h_edge = ecount;
          else if (ecount - (g_edge + S) == TO) model_finish(1);
        end else begin
          if (!iDone) model_finish(0);
          else if (ecount - h_edge == TO) model_finish(1);
        end
      end
      exp_start = m_busy && (ack_edge < 0) && (ecount < g_edge + S);
      exp_busy  = m_busy;
    end
  end

  // Stand-in multiplier. mode 0: random latency, 1: never Done,
  // 2: spurious Done pulse during Start, 3: Done held high 6 cycles.
  int mode = 0, mstate = 0, mcnt = 0;
  logic signed [15:0] ma, mb;
  always begin
    @(negedge Clock);
    if (!Resetn) begin
      mstate = 0;
      iDone  = 0;
    end else begin
      if (mstate == 0 && oStart) begin
        ma = $signed(oMplier);
        mb = $signed(oMcand);
        mstate = 1;
        if (mode == 2) begin iDone = 1; iProduct = 16'hdead; end
      end else if (mstate == 1) begin
        iDone = 0;
        if (!oStart) begin
          if (mode == 1) mstate = 4;
          else begin mcnt = $urandom_range(0, 3); mstate = 2; end
        end
      end
      if (mstate == 2) begin
        if (mcnt == 0) begin
          iDone = 1;
          iProduct = ma * mb;
          mcnt = (mode == 3) ? 6 : $urandom_range(1, 3);
          mstate = 3;
        end else mcnt--;
      end else if (mstate == 3) begin
        mcnt--;
        if (mcnt == 0) begin iDone = 0; mstate = 4; end
      end else if (mstate == 4 && !oBusy) mstate = 0;
    end
  end

  // Per-cycle comparison against the model, plus Start pulse width and ack log.
  int ack_log[$];
  int srun = 0;
  always begin
    @(posedge Clock);
    #1;
    check("start", oStart, exp_start);
    check("busy", oBusy, exp_busy);
    check("ack0", oAck0, exp_ack0);
    check("ack1", oAck1, exp_ack1);
    check("product", oProduct, exp_prod);
    check("mplier", oMplier, exp_mpl);
    check("mcand", oMcand, exp_mcd);
    check("err", oErr, exp_err);
    if (oAck0) ack_log.push_back(0);
    if (oAck1) ack_log.push_back(1);
    if (!Resetn) srun = 0;
    else if (oStart) srun++;
    else if (srun != 0) begin
      check("start_len", srun, S);
      srun = 0;
    end
  end

  task automatic wait_ack(input int k, input int budget);
    int t = 0;
    while (!(k == 0 ? oAck0 : oAck1) && t < budget) begin
      @(negedge Clock);
      t++;
    end
    check($sformatf("ack%0d_seen", k), (k == 0) ? oAck0 : oAck1, 1);
  endtask

  task automatic wait_start(input int budget);
    int t = 0;
    while (!oStart && t < budget) begin
      @(negedge Clock);
      t++;
    end
    check("start_seen", oStart, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int t, got;
    repeat (3) @(negedge Clock);
    check("rst_busy", oBusy, 0);
    check("rst_start", oStart, 0);
    check("rst_prod", oProduct, 0);
    Resetn = 1;
    @(negedge Clock);

    // Single transaction on requester 0.
    mode = 0;
    iMplier0 = 8'h03; iMcand0 = 8'h05; iReq0 = 1;
    wait_ack(0, 50);
    check("t1_prod", oProduct, 16'h000F);
    check("t1_no_ack1", oAck1, 0);
    iReq0 = 0;
    repeat (2) @(negedge Clock);

    // Both held: requester 0 was served last, so 1 goes first, then strict alternation.
    ack_log.delete();
    iMplier0 = 8'hFF; iMcand0 = 8'h02; iMplier1 = 8'h7F; iMcand1 = 8'h7F;
    iReq0 = 1; iReq1 = 1;
    got = 0; t = 0;
    while (got < 4 && t < 200) begin
      @(negedge Clock);
      t++;
      if (oAck0) begin got++; check("t2_p0", oProduct, 16'hFFFE); end
      if (oAck1) begin got++; check("t2_p1", oProduct, 16'h3F01); end
    end
    iReq0 = 0; iReq1 = 0;
    check("t2_count", got, 4);
    @(negedge Clock);
    check("t2_log_size", ack_log.size(), 4);
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check($sformatf("t2_order%0d", i), ack_log[i], (i % 2 == 0) ? 1 : 0);
    repeat (2) @(negedge Clock);

    // Operand change right after grant is ignored.
    iMplier0 = 8'h12; iMcand0 = 8'h34; iReq0 = 1;
    wait_start(20);
    iMplier0 = 8'hAB;
    @(negedge Clock);
    check("t3_latched", oMplier, 8'h12);
    wait_ack(0, 50);
    check("t3_prod", oProduct, 16'h03A8);
    iReq0 = 0;
    repeat (2) @(negedge Clock);

    // Timeout: multiplier never signals Done.
    mode = 1;
    iMplier1 = 8'h05; iMcand1 = 8'h06; iReq1 = 1;
    wait_start(20);
    t = 0;
    while (!oAck1 && t < 400) begin
      @(negedge Clock);
      t++;
    end
    check("t4_ack", oAck1, 1);
    check("t4_latency", t, S + TO);
    check("t4_err", oErr, 1);
    check("t4_prod", oProduct, 0);
    iReq1 = 0;
    repeat (2) @(negedge Clock);

    // Spurious Done during Start is ignored.
    mode = 2;
    iMplier1 = 8'h80; iMcand1 = 8'h02; iReq1 = 1;
    wait_ack(1, 60);
    check("t6_prod", oProduct, 16'hFF00);
    iReq1 = 0;
    repeat (2) @(negedge Clock);

    // Normal transaction after the timeout; the error flag stays set.
    mode = 0;
    iMplier0 = 8'h11; iMcand0 = 8'h02; iReq0 = 1;
    wait_ack(0, 50);
    check("t4b_prod", oProduct, 16'h0022);
    check("t4b_err", oErr, 1);
    iReq0 = 0;
    repeat (2) @(negedge Clock);

    // Reset in WAIT_LO: immediate clear, no ack, pointer back to requester 0.
    mode = 3;
    iMplier1 = 8'h07; iMcand1 = 8'h09; iReq1 = 1;
    t = 0;
    while (!iDone && t < 50) begin
      @(negedge Clock);
      t++;
    end
    check("t5_done_seen", iDone, 1);
    @(negedge Clock);
    Resetn = 0; iReq1 = 0;
    #1;
    check("t5_busy", oBusy, 0);
    check("t5_start", oStart, 0);
    check("t5_ack0", oAck0, 0);
    check("t5_ack1", oAck1, 0);
    check("t5_prod", oProduct, 0);
    check("t5_mplier", oMplier, 0);
    check("t5_mcand", oMcand, 0);
    check("t5_err", oErr, 0);
    repeat (2) @(negedge Clock);
    Resetn = 1;
    mode = 0;
    ack_log.delete();
    @(negedge Clock);
    iMplier0 = 8'h02; iMcand0 = 8'h03; iMplier1 = 8'h04; iMcand1 = 8'h05;
    iReq0 = 1; iReq1 = 1;
    t = 0;
    while (!(oAck0 || oAck1) && t < 60) begin
      @(negedge Clock);
      t++;
    end
    check("t5_first_is0", oAck0, 1);
    check("t5_first_prod", oProduct, 16'h0006);
    iReq0 = 0;
    wait_ack(1, 60);
    check("t5_second_prod", oProduct, 16'h0014);
    iReq1 = 0;
    repeat (2) @(negedge Clock);

    // Randomized request traffic against the reference model.
    for (int c = 0; c < 600; c++) begin
      @(negedge Clock);
      if ($urandom_range(0, 3) == 0) iReq0 = !iReq0;
      if ($urandom_range(0, 3) == 0) iReq1 = !iReq1;
      if (!iReq0) begin iMplier0 = 8'($urandom); iMcand0 = 8'($urandom); end
      if (!iReq1) begin iMplier1 = 8'($urandom); iMcand1 = 8'($urandom); end
    end
    iReq0 = 0; iReq1 = 0;
    t = 0;
    while (oBusy && t < 600) begin
      @(negedge Clock);
      t++;
    end
    check("drain", oBusy, 0);
    repeat (3) @(negedge Clock);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
